// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM request controller slice.
// Contents:
//   DEF_ADDR_W / DEF_DATA_W  default RAM geometry (16 x 8)
//   RSP_DEPTH                depth of the read-response queue
//   state_e                  controller state (INIT only used with RAM_INIT_EN)
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int RSP_DEPTH  = 2;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ram_req_ctrl_rsp_fifo2.sv
// rsp_fifo2: two-entry in-order queue for read responses.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   enqueue one word
//   pop               dequeue the head word (ignored when empty)
//   count             number of stored words (0..2)
//   head_data         oldest stored word (0 after reset)
// Push and pop in the same cycle are allowed at any occupancy; a push into a
// full queue without a pop is dropped (the controller's credit check never
// lets that happen).
module rsp_fifo2
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head_data
);

  localparam logic [1:0] FULL_CNT = 2'(RSP_DEPTH);

  logic [DATA_W-1:0] mem_r [0:1];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic              do_pop_s;
  logic              do_push_s;

  assign do_pop_s  = pop && (count_r != 2'd0);
  // When full, the slot freed by a simultaneous pop is the one written.
  assign do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: upstream request controller for a single-port synchronous RAM.
// Converts a valid/ready read/write command stream into RAM we/addr/din pins,
// captures RAM dout one cycle after each accepted read and returns the data in
// order on a valid/ready response stream backed by a 2-entry queue.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             command handshake
//   req_we, req_addr, req_wdata     command fields (wdata ignored on reads)
//   rsp_valid/rsp_ready, rsp_rdata  read response handshake and data
//   ram_we, ram_addr, ram_din       RAM control pins
//   ram_dout                        RAM registered read data
//   busy                            high while clearing the RAM after reset
// Build option: define RAM_INIT_EN to clear every RAM location to zero after
// reset before commands are accepted; otherwise commands are accepted
// immediately and busy stays low.
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  logic              in_init_s;
  logic [ADDR_W-1:0] init_addr_s;
  logic              rd_inflight_r;
  logic [1:0]        q_count_s;
  logic [2:0]        occ_s;
  logic              pop_s;
  logic              credit_ok_s;
  logic              req_accept_s;

`ifdef RAM_INIT_EN
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ADDR_W-1:0] init_cnt_r;
  logic [ADDR_W-1:0] init_cnt_nxt_s;

  // State and clear-address counter registers; reset restarts the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_INIT;
      init_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      init_cnt_r <= init_cnt_nxt_s;
    end
  end

  // Next state: walk every address once, then run.
  always_comb begin
    state_nxt_s    = state_r;
    init_cnt_nxt_s = init_cnt_r;
    case (state_r)
      ST_INIT: begin
        init_cnt_nxt_s = init_cnt_r + CNT_ONE;
        if (init_cnt_r == CNT_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s    = ST_INIT;
        init_cnt_nxt_s = '0;
      end
    endcase
  end

  assign in_init_s   = (state_r == ST_INIT);
  assign init_addr_s = init_cnt_r;
`else
  assign in_init_s   = 1'b0;
  assign init_addr_s = '0;
`endif

  // Occupancy counts the read in flight plus queued data, so a read is only
  // accepted when its response is guaranteed a queue slot.
  assign occ_s        = {2'b00, rd_inflight_r} + {1'b0, q_count_s};
  assign rsp_valid    = (q_count_s != 2'd0);
  assign pop_s        = rsp_valid && rsp_ready;
  assign credit_ok_s  = (occ_s < (3'd2 + {2'b00, pop_s}));
  assign req_ready    = !in_init_s && credit_ok_s;
  assign req_accept_s = req_valid && req_ready;
  assign busy         = in_init_s;

  // Marks the cycle in which RAM dout holds data for an accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_inflight_r <= 1'b0;
    end else begin
      rd_inflight_r <= req_accept_s && !req_we;
    end
  end

  // RAM pin muxing: clearing sweep during init, command fields otherwise.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = req_addr;
    ram_din  = req_wdata;
    if (in_init_s) begin
      ram_we   = 1'b1;
      ram_addr = init_addr_s;
      ram_din  = '0;
    end else begin
      ram_we   = req_accept_s && req_we;
      ram_addr = req_addr;
      ram_din  = req_wdata;
    end
  end

  rsp_fifo2 #(
    .DATA_W (DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight_r),
    .push_data (ram_dout),
    .pop       (pop_s),
    .count     (q_count_s),
    .head_data (rsp_rdata)
  );

endmodule
